// File: rtl/sad_frame_accumulator.sv
// Pixel-serial frame reducer: sums |pixel| or signed pixel over NUM_PIX beats,
// presents each frame sum on a valid/ready port and tracks the minimum sum and its index.
module sad_frame_accumulator #(
  parameter int PIX_W   = 12,
  parameter int NUM_PIX = 4096,
  parameter int SUM_W   = 25,
  parameter int IDX_W   = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic signed [PIX_W-1:0] in_pixel_i,
  input  logic                    abs_mode_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic signed [SUM_W-1:0] out_sum_o,
  output logic        [IDX_W-1:0] out_idx_o,
  output logic signed [SUM_W-1:0] best_sum_o,
  output logic        [IDX_W-1:0] best_idx_o,
  output logic                    best_valid_o
);

  localparam int CNT_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PIX - 1);

  typedef enum logic {S_ACCUM, S_DONE} state_t;

  state_t                  state_q;
  logic signed [SUM_W-1:0] acc_q;
  logic        [CNT_W-1:0] cnt_q;
  logic        [IDX_W-1:0] frame_idx_q;
  logic                    out_valid_q;
  logic signed [SUM_W-1:0] out_sum_q;
  logic        [IDX_W-1:0] out_idx_q;
  logic signed [SUM_W-1:0] best_sum_q;
  logic        [IDX_W-1:0] best_idx_q;
  logic                    best_valid_q;

  logic signed [PIX_W:0]   pix_se;
  logic        [PIX_W:0]   pix_mag;
  logic signed [SUM_W-1:0] term;
  logic signed [SUM_W-1:0] sum_d;
  logic                    fire;
  logic                    last_beat;

  // Magnitude is formed one bit wider so the most negative pixel does not wrap.
  always_comb begin
    pix_se  = {in_pixel_i[PIX_W-1], in_pixel_i};
    pix_mag = pix_se[PIX_W] ? $unsigned(-pix_se) : $unsigned(pix_se);
    term    = abs_mode_i ? $signed({{(SUM_W-PIX_W-1){1'b0}}, pix_mag})
                         : {{(SUM_W-PIX_W){in_pixel_i[PIX_W-1]}}, in_pixel_i};
    sum_d   = acc_q + term;
  end

  assign in_ready_o = (state_q == S_ACCUM) & ~clear_i;
  assign fire       = in_valid_i & in_ready_o;
  assign last_beat  = (cnt_q == LAST_CNT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_ACCUM;
      acc_q        <= '0;
      cnt_q        <= '0;
      frame_idx_q  <= '0;
      out_valid_q  <= 1'b0;
      out_sum_q    <= '0;
      out_idx_q    <= '0;
      best_sum_q   <= '0;
      best_idx_q   <= '0;
      best_valid_q <= 1'b0;
    end else if (clear_i) begin
      state_q      <= S_ACCUM;
      acc_q        <= '0;
      cnt_q        <= '0;
      frame_idx_q  <= '0;
      out_valid_q  <= 1'b0;
      best_sum_q   <= '0;
      best_idx_q   <= '0;
      best_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_ACCUM: begin
          if (fire) begin
            if (last_beat) begin
              state_q     <= S_DONE;
              acc_q       <= '0;
              cnt_q       <= '0;
              out_valid_q <= 1'b1;
              out_sum_q   <= sum_d;
              out_idx_q   <= frame_idx_q;
              // Strict compare keeps the earlier frame on ties.
              if (!best_valid_q || (sum_d < best_sum_q)) begin
                best_sum_q   <= sum_d;
                best_idx_q   <= frame_idx_q;
                best_valid_q <= 1'b1;
              end
            end else begin
              acc_q <= sum_d;
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (out_ready_i) begin
            state_q     <= S_ACCUM;
            out_valid_q <= 1'b0;
            frame_idx_q <= frame_idx_q + 1'b1;
          end
        end
        default: state_q <= S_ACCUM;
      endcase
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_sum_o    = out_sum_q;
  assign out_idx_o    = out_idx_q;
  assign best_sum_o   = best_sum_q;
  assign best_idx_o   = best_idx_q;
  assign best_valid_o = best_valid_q;

endmodule
